counter_monitor: RTL and testbench
==================================

COUNTER_MONITOR -- requirements
Module: counter_monitor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the width of the observed count bus.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port enable, input, 1 bit: the count-enable driving the observed counter, sampled alongside it.
REQ-005 The block SHALL have port count, input, WIDTH bits: observed counter value.
REQ-006 The block SHALL have port overflow, input, 1 bit: observed counter overflow flag.
REQ-007 The block SHALL have port clear, input, 1 bit: synchronous clear of err_count and wrap_count.
REQ-008 The block SHALL have port locked, output, 1 bit: high while in TRACK.
REQ-009 The block SHALL have port mismatch, output, 1 bit: one-cycle pulse per detected error.
REQ-010 The block SHALL have port err_count, output, 16 bits: saturating mismatch counter.
REQ-011 The block SHALL have port wrap_count, output, 16 bits: saturating count of observed MAX->0 wraps.

Function
REQ-012 The block SHALL sample enable, count and overflow on every rising clk edge; prev_count and prev_en hold the previous sample.
REQ-013 The block SHALL compute expected = prev_en ? prev_count+1 : prev_count, modulo 2^WIDTH; MAX = 2^WIDTH-1.
REQ-014 The FSM SHALL have states IDLE, ACQUIRE, TRACK, ERROR.
REQ-015 IDLE SHALL move to ACQUIRE on the first edge after reset release.
REQ-016 ACQUIRE SHALL load prev_count/prev_en from the current sample, perform no check, and move to TRACK.
REQ-017 TRACK SHALL compare each sample against expected; on mismatch it SHALL move to ERROR, otherwise stay in TRACK.
REQ-018 ERROR SHALL last exactly one cycle, perform no check, and move to ACQUIRE (resynchronise to the observed value).
REQ-019 mismatch SHALL be registered: high for exactly the one cycle following the edge at which the bad sample was taken.
REQ-020 err_count SHALL increment by 1 per mismatch and saturate at 16'hFFFF.
REQ-021 wrap_count SHALL increment when in TRACK, prev_count==MAX, prev_en==1 and count==0, saturating at 16'hFFFF.
REQ-022 clear SHALL zero both counters on the next edge; clear with a simultaneous increment SHALL yield 0 (clear wins), while mismatch still pulses.
REQ-023 locked SHALL be high exactly while the state is TRACK.

Reset
REQ-024 On rst assertion, state SHALL go to IDLE immediately, without waiting for clk.
REQ-025 While rst is asserted: locked=0, mismatch=0, err_count=0, wrap_count=0, prev_count=0, prev_en=0.
REQ-026 Reset mid-TRACK SHALL discard history; after release the block SHALL re-acquire via IDLE->ACQUIRE before checking again.

Configuration
REQ-027 Macro COUNTER_MONITOR_OVF_CHECK_EN SHALL control overflow checking.
REQ-028 When the macro is defined, TRACK SHALL also flag a mismatch when overflow != (count==MAX).
REQ-029 When the macro is undefined, the overflow input SHALL be ignored and only count SHALL be checked.

Verification (WIDTH=8)
REQ-030 Reset hold, then release: locked=0 in IDLE/ACQUIRE; locked=1 from the 2nd edge after release; err_count=0.
REQ-031 Clean count 0..255..0 with enable=1 and overflow high only at 8'hFF: mismatch never asserts; wrap_count=1 after the wrap.
REQ-032 Inject count jump 8'h10->8'h13 in TRACK: one mismatch pulse; err_count=1; ERROR then ACQUIRE, locked=1 again after two cycles; following clean counting gives no further errors.
REQ-033 Hold enable=0 with count held at 8'h05: no mismatch. With enable=0 but count stepping 8'h05->8'h06: mismatch, err_count increments.
REQ-034 With the macro defined, overflow=1 at count=8'h7F: mismatch. With the macro undefined, same stimulus: no mismatch.
REQ-035 Force 65540 errors: err_count=16'hFFFF. Assert clear together with a mismatch: err_count=0 and mismatch pulses.

Source files
------------

// File: rtl/counter_monitor.sv
// counter_monitor: watches an external up-counter (count/enable/overflow) and
// checks that every sample follows from the previous one. After reset it
// acquires the observed value, then tracks it. On the first bad sample it
// pulses mismatch, spends one cycle in ERROR, and re-acquires. It also counts
// errors and MAX->0 wraps with saturating 16-bit counters.
//
// Build option: define COUNTER_MONITOR_OVF_CHECK_EN to also require, while
// tracking, that overflow is high exactly when count == MAX. Without it the
// overflow input is ignored.
//
// Sampling protocol: there is no valid/ready handshake. Every rising clk edge
// takes one sample of {enable, count, overflow}. Outputs are registered, so
// mismatch describes the sample taken at the previous edge. state_dbg shows
// the FSM state (0 IDLE, 1 ACQUIRE, 2 TRACK, 3 ERROR).
module counter_monitor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] count,
    input  logic             overflow,
    input  logic             clear,
    output logic             locked,
    output logic             mismatch,
    output logic [15:0]      err_count,
    output logic [15:0]      wrap_count,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2,
        ERROR   = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] MAX = '1;
    localparam logic [15:0] SAT = 16'hFFFF;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] prev_count;
    logic             prev_en;
    logic [WIDTH-1:0] expected;
    logic             bad;
    logic             wrap_hit;
    logic             mismatch_q;
    logic [15:0]      err_cnt_q;
    logic [15:0]      err_cnt_d;
    logic [15:0]      wrap_cnt_q;
    logic [15:0]      wrap_cnt_d;

`ifndef COUNTER_MONITOR_OVF_CHECK_EN
    // Overflow has no effect in this build.
    logic unused_overflow;
    assign unused_overflow = overflow;
`endif

    // Value the observed counter should show now, from the previous sample.
    assign expected = prev_en ? prev_count + {{(WIDTH-1){1'b0}}, 1'b1} : prev_count;

    // Next state, error detection and wrap detection; checks run only in TRACK.
    always_comb begin
        state_d  = state_q;
        bad      = 1'b0;
        wrap_hit = 1'b0;
        case (state_q)
            IDLE:    state_d = ACQUIRE;
            ACQUIRE: state_d = TRACK;
            TRACK: begin
                bad = (count != expected);
`ifdef COUNTER_MONITOR_OVF_CHECK_EN
                if (overflow != (count == MAX)) begin
                    bad = 1'b1;
                end
`endif
                wrap_hit = (prev_count == MAX) && prev_en && (count == '0);
                if (bad) begin
                    state_d = ERROR;
                end
            end
            ERROR:   state_d = ACQUIRE;
            default: state_d = IDLE;
        endcase
    end

    // Saturating counters; clear takes priority over a same-cycle increment.
    always_comb begin
        err_cnt_d  = err_cnt_q;
        wrap_cnt_d = wrap_cnt_q;
        if (clear) begin
            err_cnt_d  = 16'h0000;
            wrap_cnt_d = 16'h0000;
        end else begin
            if (bad && (err_cnt_q != SAT)) begin
                err_cnt_d = err_cnt_q + 16'h0001;
            end
            if (wrap_hit && (wrap_cnt_q != SAT)) begin
                wrap_cnt_d = wrap_cnt_q + 16'h0001;
            end
        end
    end

    // FSM state register; reset forces IDLE without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sample history, registered mismatch pulse and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_count <= '0;
            prev_en    <= 1'b0;
            mismatch_q <= 1'b0;
            err_cnt_q  <= 16'h0000;
            wrap_cnt_q <= 16'h0000;
        end else begin
            prev_count <= count;
            prev_en    <= enable;
            mismatch_q <= bad;
            err_cnt_q  <= err_cnt_d;
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign locked     = (state_q == TRACK);
    assign mismatch   = mismatch_q;
    assign err_count  = err_cnt_q;
    assign wrap_count = wrap_cnt_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_counter_monitor.sv
// Bench for counter_monitor (WIDTH=8). The driver applies one sample per
// cycle on the falling edge and queues the outputs expected after the next
// rising edge. The monitor pops and compares each queued entry shortly after
// that edge, or right away for the asynchronous reset check.
// Packed output word: {state_dbg[1:0], locked, mismatch, err_count, wrap_count}.
module tb_counter_monitor;

  localparam int W = 36;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACQ   = 2'd1;
  localparam logic [1:0] S_TRACK = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [7:0]  count;
  logic        overflow;
  logic        clear;
  logic        locked;
  logic        mismatch;
  logic [15:0] err_count;
  logic [15:0] wrap_count;
  logic [1:0]  state_dbg;

  logic [W-1:0] exp_q[$];
  int           checks;
  int           failures;
  event         chk_ev;

  counter_monitor #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .count      (count),
    .overflow   (overflow),
    .clear      (clear),
    .locked     (locked),
    .mismatch   (mismatch),
    .err_count  (err_count),
    .wrap_count (wrap_count),
    .state_dbg  (state_dbg)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver: one sample per call, expected outputs after the next rising edge
  task automatic step(input logic r, input logic en, input logic [7:0] c,
                      input logic ovf, input logic clr, input logic [1:0] st,
                      input logic mis, input logic [15:0] err, input logic [15:0] wrap);
    @(negedge clk);
    rst      = r;
    enable   = en;
    count    = c;
    overflow = ovf;
    clear    = clr;
    exp_q.push_back({st, (st == S_TRACK), mis, err, wrap});
  endtask

  // scoreboard monitor
  initial begin
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {state_dbg, locked, mismatch, err_count, wrap_count};
        checks++;
        if (act_v !== exp_v) begin
          failures++;
          $display("FAIL out_word[%0d] t=%0t actual st=%0d lock=%0b mis=%0b err=%h wrap=%h required st=%0d lock=%0b mis=%0b err=%h wrap=%h",
                   checks, $time, act_v[35:34], act_v[33], act_v[32], act_v[31:16], act_v[15:0],
                   exp_v[35:34], exp_v[33], exp_v[32], exp_v[31:16], exp_v[15:0]);
        end
      end
    end
  end

  logic [15:0] sat_exp [5];
  logic [7:0]  cur;

  initial begin
    sat_exp = '{16'hFFFD, 16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    enable   = 1'b0;
    count    = 8'h00;
    overflow = 1'b0;
    clear    = 1'b0;

    // reset hold, then release and acquire
    repeat (3) step(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, S_IDLE, 1'b0, 16'h0, 16'h0);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, S_ACQ,   1'b0, 16'h0, 16'h0);
    step(1'b0, 1'b1, 8'h01, 1'b0, 1'b0, S_TRACK, 1'b0, 16'h0, 16'h0);

    // clean count up to 0xFF, wrap to 0, continue to 0x10
    for (int c = 2; c < 256; c++)
      step(1'b0, 1'b1, 8'(c), (c == 255), 1'b0, S_TRACK, 1'b0, 16'h0, 16'h0);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, S_TRACK, 1'b0, 16'h0, 16'h1);
    for (int c = 1; c <= 16; c++)
      step(1'b0, 1'b1, 8'(c), 1'b0, 1'b0, S_TRACK, 1'b0, 16'h0, 16'h1);

    // jump 0x10 -> 0x13, then resynchronise and count cleanly
    step(1'b0, 1'b1, 8'h13, 1'b0, 1'b0, S_ERR,   1'b1, 16'h1, 16'h1);
    step(1'b0, 1'b1, 8'h14, 1'b0, 1'b0, S_ACQ,   1'b0, 16'h1, 16'h1);
    step(1'b0, 1'b1, 8'h15, 1'b0, 1'b0, S_TRACK, 1'b0, 16'h1, 16'h1);
    for (int c = 16'h16; c <= 16'h1F; c++)
      step(1'b0, 1'b1, 8'(c), 1'b0, 1'b0, S_TRACK, 1'b0, 16'h1, 16'h1);

    // preload the error counter just below saturation, then drive 5 errors
    step(1'b0, 1'b1, 8'h20, 1'b0, 1'b0, S_TRACK, 1'b0, 16'hFFFC, 16'h1);
    #1 force dut.err_cnt_q = 16'hFFFC;
    #1 release dut.err_cnt_q;
    cur = 8'h20;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, cur + 8'd3, 1'b0, 1'b0, S_ERR,   1'b1, sat_exp[i], 16'h1);
      step(1'b0, 1'b1, cur + 8'd4, 1'b0, 1'b0, S_ACQ,   1'b0, sat_exp[i], 16'h1);
      step(1'b0, 1'b1, cur + 8'd5, 1'b0, 1'b0, S_TRACK, 1'b0, sat_exp[i], 16'h1);
      cur = cur + 8'd5;
    end

    // clear together with a mismatch: counters zero, pulse still present
    step(1'b0, 1'b1, cur + 8'd3, 1'b0, 1'b1, S_ERR,   1'b1, 16'h0, 16'h0);
    step(1'b0, 1'b1, cur + 8'd4, 1'b0, 1'b0, S_ACQ,   1'b0, 16'h0, 16'h0);
    step(1'b0, 1'b1, cur + 8'd5, 1'b0, 1'b0, S_TRACK, 1'b0, 16'h0, 16'h0);
    cur = cur + 8'd5;

    // one more error so reset has something to discard
    step(1'b0, 1'b1, cur + 8'd3, 1'b0, 1'b0, S_ERR,   1'b1, 16'h1, 16'h0);
    step(1'b0, 1'b1, cur + 8'd4, 1'b0, 1'b0, S_ACQ,   1'b0, 16'h1, 16'h0);
    step(1'b0, 1'b1, cur + 8'd5, 1'b0, 1'b0, S_TRACK, 1'b0, 16'h1, 16'h0);
    cur = cur + 8'd5;
    step(1'b0, 1'b1, cur + 8'd1, 1'b0, 1'b0, S_TRACK, 1'b0, 16'h1, 16'h0);

    // asynchronous reset mid-TRACK, checked before any clock edge
    @(negedge clk);
    rst = 1'b1;
    exp_q.push_back({S_IDLE, 1'b0, 1'b0, 16'h0, 16'h0});
    -> chk_ev;
    step(1'b1, 1'b0, 8'h05, 1'b0, 1'b0, S_IDLE, 1'b0, 16'h0, 16'h0);

    // re-acquire at 0x05 with enable low; held count is clean
    step(1'b0, 1'b0, 8'h05, 1'b0, 1'b0, S_ACQ, 1'b0, 16'h0, 16'h0);
    repeat (4) step(1'b0, 1'b0, 8'h05, 1'b0, 1'b0, S_TRACK, 1'b0, 16'h0, 16'h0);
    // count steps while enable is low: error
    step(1'b0, 1'b0, 8'h06, 1'b0, 1'b0, S_ERR, 1'b1, 16'h1, 16'h0);

    // overflow asserted at 0x7F
    step(1'b0, 1'b1, 8'h7C, 1'b0, 1'b0, S_ACQ,   1'b0, 16'h1, 16'h0);
    step(1'b0, 1'b1, 8'h7D, 1'b0, 1'b0, S_TRACK, 1'b0, 16'h1, 16'h0);
    step(1'b0, 1'b1, 8'h7E, 1'b0, 1'b0, S_TRACK, 1'b0, 16'h1, 16'h0);
`ifdef COUNTER_MONITOR_OVF_CHECK_EN
    step(1'b0, 1'b1, 8'h7F, 1'b1, 1'b0, S_ERR,   1'b1, 16'h2, 16'h0);
    step(1'b0, 1'b1, 8'h80, 1'b0, 1'b0, S_ACQ,   1'b0, 16'h2, 16'h0);
    step(1'b0, 1'b1, 8'h81, 1'b0, 1'b0, S_TRACK, 1'b0, 16'h2, 16'h0);
    step(1'b0, 1'b1, 8'h82, 1'b0, 1'b0, S_TRACK, 1'b0, 16'h2, 16'h0);
`else
    step(1'b0, 1'b1, 8'h7F, 1'b1, 1'b0, S_TRACK, 1'b0, 16'h1, 16'h0);
    step(1'b0, 1'b1, 8'h80, 1'b0, 1'b0, S_TRACK, 1'b0, 16'h1, 16'h0);
    step(1'b0, 1'b1, 8'h81, 1'b0, 1'b0, S_TRACK, 1'b0, 16'h1, 16'h0);
    step(1'b0, 1'b1, 8'h82, 1'b0, 1'b0, S_TRACK, 1'b0, 16'h1, 16'h0);
`endif

    // drain the scoreboard within a fixed cycle budget
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain actual pending=%0d required pending=0", exp_q.size());
    end

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
